// File: rtl/spi_master.sv
// SPI master, mode 0 (sck idle low, sample on rise), MSB first.
// Valid/ready word interface with optional chip-select hold between words.
module spi_master #(
  parameter int size = 8,
  parameter int div  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            sck,
  output logic            sdo,
  input  logic            sdi,
  output logic            scs,
  input  logic [size-1:0] tx_data,
  input  logic            tx_last,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [size-1:0] rx_data,
  output logic            rx_valid,
  output logic            busy
);

  localparam int BW = $clog2(size + 1);
  localparam int HW = $clog2(div + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_t;

  state_t          state, state_n;
  logic            sck_n, sdo_n, scs_n;
  logic [size-1:0] sh, sh_n;
  logic [BW-1:0]   bcnt, bcnt_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic            last, last_n;
  logic [size-1:0] rx_data_n;
  logic            rx_valid_n;
  logic            tx_ready_n;
  logic            busy_n;
  logic            accept;

  assign accept = tx_valid && tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sck      <= 1'b0;
      sdo      <= 1'b0;
      scs      <= 1'b0;
      sh       <= '0;
      bcnt     <= '0;
      hcnt     <= '0;
      last     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      sck      <= sck_n;
      sdo      <= sdo_n;
      scs      <= scs_n;
      sh       <= sh_n;
      bcnt     <= bcnt_n;
      hcnt     <= hcnt_n;
      last     <= last_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_ready <= tx_ready_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    sck_n      = sck;
    sdo_n      = sdo;
    scs_n      = scs;
    sh_n       = sh;
    bcnt_n     = bcnt;
    hcnt_n     = hcnt;
    last_n     = last;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    unique case (state)
      IDLE, HOLD: begin
        sck_n = 1'b0;
        if (accept) begin
          scs_n   = 1'b1;
          sdo_n   = tx_data[size-1];
          sh_n    = tx_data;
          bcnt_n  = BW'(size);
          hcnt_n  = HW'(div);
          last_n  = tx_last;
          state_n = LOW;
        end
      end
      LOW: begin
        if (hcnt == HW'(1)) begin
          sck_n   = 1'b1;
          sh_n    = {sh[size-2:0], sdi};
          hcnt_n  = HW'(div);
          state_n = HIGH;
        end else begin
          hcnt_n = hcnt - HW'(1);
        end
      end
      HIGH: begin
        if (hcnt == HW'(1)) begin
          sck_n  = 1'b0;
          bcnt_n = bcnt - BW'(1);
          hcnt_n = HW'(div);
          if (bcnt == BW'(1)) begin
            // last bit already shifted in on the rising edge
            rx_data_n  = sh;
            rx_valid_n = 1'b1;
            if (last) begin
              scs_n   = 1'b0;
              state_n = GAP;
            end else begin
              state_n = HOLD;
            end
          end else begin
            sdo_n   = sh[size-1];
            state_n = LOW;
          end
        end else begin
          hcnt_n = hcnt - HW'(1);
        end
      end
      GAP: begin
        if (hcnt == HW'(1)) begin
          state_n = IDLE;
        end else begin
          hcnt_n = hcnt - HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        sck_n   = 1'b0;
        scs_n   = 1'b0;
      end
    endcase
  end

  // ready and busy follow the state being entered so they stay registered
  always_comb begin
    tx_ready_n = (state_n == IDLE) || (state_n == HOLD);
    busy_n     = (state_n != IDLE);
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, slave model, back-to-back,
// mid-word reset, div=1 and tx_data churn; scoreboard of received words.
module tb_spi_master;

  typedef struct {
    logic [7:0] d;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       sck0, sdo0, sdi0, scs0;
  logic [7:0] tx_data0;
  logic       tx_last0, tx_valid0, tx_ready0;
  logic [7:0] rx_data0;
  logic       rx_valid0, busy0;
  logic       sck1, sdo1, sdi1, scs1;
  logic [7:0] tx_data1;
  logic       tx_last1, tx_valid1, tx_ready1;
  logic [7:0] rx_data1;
  logic       rx_valid1, busy1;

  logic       use_slave;
  logic [7:0] pdi;
  logic [7:0] s_rx;
  logic       s_sdo;
  int         s_base;
  int         pulses0, pulses1;
  int         cyc, scs_hi;
  int         checks, errors;
  exp_t       q0[$];
  exp_t       q1[$];

  spi_master #(.size(8), .div(4)) dut0 (
    .clk(clk), .rst(rst), .sck(sck0), .sdo(sdo0), .sdi(sdi0),
    .scs(scs0), .tx_data(tx_data0), .tx_last(tx_last0),
    .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0)
  );

  spi_master #(.size(8), .div(1)) dut1 (
    .clk(clk), .rst(rst), .sck(sck1), .sdo(sdo1), .sdi(sdi1),
    .scs(scs1), .tx_data(tx_data1), .tx_last(tx_last1),
    .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge sck0) begin
    pulses0 = pulses0 + 1;
    s_rx    = {s_rx[6:0], sdo0};
  end
  always @(posedge sck1) pulses1 = pulses1 + 1;
  always @(posedge scs0) s_base = pulses0;

  // slave presents bit 7-k before the k-th rise (0-based)
  always_comb begin
    int idx;
    idx   = 7 - (pulses0 - s_base);
    s_sdo = (idx >= 0 && idx <= 7) ? pdi[idx[2:0]] : 1'b0;
  end

  assign sdi0 = use_slave ? s_sdo : sdo0;
  assign sdi1 = sdo1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (scs0) scs_hi++;
    if (rx_valid0) begin
      if (q0.size() == 0) begin
        check("rx0_unexpected", 32'(rx_data0), 32'hFFFF_FFFF);
      end else begin
        e = q0.pop_front();
        check("rx0_data", 32'(rx_data0), 32'(e.d));
        check("rx0_latency", 32'(cyc - e.acc), 32'd64);
      end
    end
    if (rx_valid1) begin
      if (q1.size() == 0) begin
        check("rx1_unexpected", 32'(rx_data1), 32'hFFFF_FFFF);
      end else begin
        e = q1.pop_front();
        check("rx1_data", 32'(rx_data1), 32'(e.d));
        check("rx1_latency", 32'(cyc - e.acc), 32'd16);
      end
    end
  endtask

  task automatic send0(input logic [7:0] d, input logic last,
                       input logic hold, input logic push,
                       input logic [7:0] e);
    int n;
    exp_t x;
    n         = 0;
    tx_data0  = d;
    tx_last0  = last;
    tx_valid0 = 1'b1;
    while (!tx_ready0 && n < 300) begin
      tick();
      n++;
    end
    if (!tx_ready0) check("tx0_ready_timeout", 32'(tx_ready0), 32'd1);
    x.d   = e;
    x.acc = cyc + 1;
    if (push) q0.push_back(x);
    tick();
    if (!hold) tx_valid0 = 1'b0;
  endtask

  task automatic wait_rx0();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (q0.size() != 0) begin
      check("rx0_timeout", 32'(q0.size()), 32'd0);
      q0.delete();
    end
  endtask

  task automatic wait_rx1();
    int n;
    n = 0;
    while (q1.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (q1.size() != 0) begin
      check("rx1_timeout", 32'(q1.size()), 32'd0);
      q1.delete();
    end
  endtask

  initial begin
    int   base;
    int   n;
    exp_t x;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    scs_hi    = 0;
    pulses0   = 0;
    pulses1   = 0;
    s_rx      = 8'h00;
    s_base    = 0;
    pdi       = 8'h81;
    use_slave = 1'b0;
    tx_data0  = 8'h00;
    tx_last0  = 1'b0;
    tx_valid0 = 1'b0;
    tx_data1  = 8'h00;
    tx_last1  = 1'b0;
    tx_valid1 = 1'b0;
    rst       = 1'b1;

    // reset state
    #1;
    check("rst_sck", 32'(sck0), 32'd0);
    check("rst_scs", 32'(scs0), 32'd0);
    check("rst_sdo", 32'(sdo0), 32'd0);
    check("rst_rx_data", 32'(rx_data0), 32'd0);
    check("rst_tx_ready", 32'(tx_ready0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rel_tx_ready_low", 32'(tx_ready0), 32'd0);
    tick();
    check("rel_tx_ready_high", 32'(tx_ready0), 32'd1);

    // loopback 0xA5, single frame
    base   = pulses0;
    scs_hi = 0;
    send0(8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5);
    repeat (3) tick();
    check("sck_before_rise", 32'(sck0), 32'd0);
    tick();
    check("sck_first_rise", 32'(sck0), 32'd1);
    wait_rx0();
    check("a5_pulses", 32'(pulses0 - base), 32'd8);
    check("a5_scs_high_cycles", 32'(scs_hi), 32'd64);
    check("gap_scs", 32'(scs0), 32'd0);
    check("gap_busy", 32'(busy0), 32'd1);
    check("gap_tx_ready", 32'(tx_ready0), 32'd0);
    repeat (3) tick();
    check("gap_end_tx_ready", 32'(tx_ready0), 32'd0);
    tick();
    check("idle_tx_ready", 32'(tx_ready0), 32'd1);
    check("idle_busy", 32'(busy0), 32'd0);

    // external slave returns 0x81 while receiving 0xA5
    use_slave = 1'b1;
    s_rx      = 8'h00;
    send0(8'hA5, 1'b1, 1'b0, 1'b1, 8'h81);
    wait_rx0();
    check("slave_pdo", 32'(s_rx), 32'hA5);
    repeat (6) tick();
    use_slave = 1'b0;

    // back-to-back words with scs held
    base   = pulses0;
    scs_hi = 0;
    send0(8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5);
    send0(8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A);
    wait_rx0();
    check("b2b_pulses", 32'(pulses0 - base), 32'd16);
    check("b2b_scs_high_cycles", 32'(scs_hi), 32'd129);
    repeat (6) tick();

    // reset after third sck rise aborts the word
    base = pulses0;
    send0(8'hC3, 1'b1, 1'b0, 1'b0, 8'h00);
    n = 0;
    while ((pulses0 - base) < 3 && n < 100) begin
      tick();
      n++;
    end
    check("mid_rises", 32'(pulses0 - base), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sck", 32'(sck0), 32'd0);
    check("mid_rst_scs", 32'(scs0), 32'd0);
    check("mid_rst_sdo", 32'(sdo0), 32'd0);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("mid_rel_tx_ready_low", 32'(tx_ready0), 32'd0);
    tick();
    check("mid_rel_tx_ready_high", 32'(tx_ready0), 32'd1);
    send0(8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A);
    wait_rx0();
    repeat (6) tick();

    // tx_data churn while the word is on the wire
    base = pulses0;
    send0(8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C);
    repeat (40) begin
      tick();
      tx_data0 = 8'($urandom);
      tx_last0 = 1'($urandom);
    end
    tx_valid0 = 1'b0;
    wait_rx0();
    check("churn_pulses", 32'(pulses0 - base), 32'd8);
    repeat (6) tick();

    // div=1 loopback
    base      = pulses1;
    tx_data1  = 8'h81;
    tx_last1  = 1'b1;
    tx_valid1 = 1'b1;
    n = 0;
    while (!tx_ready1 && n < 50) begin
      tick();
      n++;
    end
    check("div1_ready", 32'(tx_ready1), 32'd1);
    x.d   = 8'h81;
    x.acc = cyc + 1;
    q1.push_back(x);
    tick();
    tx_valid1 = 1'b0;
    tick();
    check("div1_sck_high", 32'(sck1), 32'd1);
    tick();
    check("div1_sck_low", 32'(sck1), 32'd0);
    wait_rx1();
    check("div1_pulses", 32'(pulses1 - base), 32'd8);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: size, default 8, word length in bits (size >= 2).
REQ-002 Parameter: div, default 4, system clocks per sck half-period (div >= 1).
REQ-003 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: sck  output  1  serial clock to slave sck; idle low.
REQ-006 Port: sdo  output  1  serial data to slave sdi; MSB first.
REQ-007 Port: sdi  input  1  serial data from slave sdo.
REQ-008 Port: scs  output  1  slave select to slave scs; active-high.
REQ-009 Port: tx_data  input  size  word to transmit.
REQ-010 Port: tx_last  input  1  qualifies tx_data; 1 = release scs after this word.
REQ-011 Port: tx_valid  input  1  tx_data/tx_last valid.
REQ-012 Port: tx_ready  output  1  master accepts a word on this cycle.
REQ-013 Port: rx_data  output  size  last received word; held until next word completes.
REQ-014 Port: rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-015 Port: busy  output  1  high whenever scs is high or a GAP is in progress.

Function
REQ-016 States: IDLE, LOW, HIGH, HOLD, GAP; all outputs registered.
REQ-017 Handshake: a word is accepted on a clock edge where tx_valid and tx_ready are both 1; tx_data/tx_last are sampled only then.
REQ-018 tx_ready is 1 in IDLE and HOLD only; 0 in LOW, HIGH, GAP.
REQ-019 IDLE: scs=0, sck=0; on accept -> scs=1, sdo=tx_data[size-1], shift reg loaded, bit count=size, half-period count=div, -> LOW.
REQ-020 LOW: sck=0 for div clocks; then sck=1, sdi sampled into shift reg LSB (shift left), -> HIGH.
REQ-021 HIGH: sck=1 for div clocks; then sck=0, bit count decremented.
REQ-022 HIGH exit with bits remaining: sdo = next bit (MSB of shifted reg) on the same edge sck falls, -> LOW.
REQ-023 HIGH exit on final bit: rx_data = received word, rx_valid=1 for exactly one cycle; tx_last latched 1 -> GAP, else -> HOLD.
REQ-024 Latency: sck rises div clocks after acceptance edge; rx_valid asserts 2*div*size clocks after acceptance edge; exactly size sck pulses per word.
REQ-025 HOLD: scs stays 1, sck=0; waits indefinitely; on accept behaves as IDLE accept (no scs deassertion) -> LOW.
REQ-026 GAP: scs=0, sck=0 for div clocks, then -> IDLE; minimum scs-low time between frames is div clocks.
REQ-027 A word accepted in HOLD on the same edge rx_valid pulses is not possible (HOLD entered after pulse edge); no data lost for back-to-back words.
REQ-028 tx_data changes while tx_ready=0 have no effect on the serial stream.
REQ-029 Bit counter and half-period counter widths sized for size and div respectively; no wrap-around of either during a word.

Reset
REQ-030 On rst assertion, immediately (no clock): state=IDLE, sck=0, sdo=0, scs=0, rx_data=0, rx_valid=0, tx_ready=0, busy=0.
REQ-031 Reset mid-word aborts the word; no rx_valid for the partial word; scs drops at once.
REQ-032 tx_ready rises on first clk edge after rst release.

Verification (size=8, div=4 unless stated)
REQ-033 Loopback sdo->sdi, send 0xA5 tx_last=1 -> 8 sck pulses, rx_data=0xA5, rx_valid at +64 clocks, scs high 64 clocks then low for 4 clocks, tx_ready back after GAP.
REQ-034 Master driving spi slave (size 8) with slave pdi=0x81, send 0xA5 last=1 -> rx_data=0x81, slave pdo=0xA5.
REQ-035 Back-to-back 0xA5 (last=0) then 0x5A (last=1) with tx_valid held -> scs continuously high, 16 sck pulses, rx_valid pulses twice (0xA5, 0x5A loopback).
REQ-036 rst pulse after 3rd sck rise -> sck/scs/sdo low immediately, no rx_valid; subsequent 0x5A frame received correctly.
REQ-037 div=1, loopback 0x81 -> sck period 2 clocks, rx_valid at +16 clocks, rx_data=0x81.
REQ-038 tx_valid held high with changing tx_data during LOW/HIGH -> serial stream matches only the word sampled at acceptance.
